// File: rtl/sniff_pkg.sv
// Shared definitions for the sniffer capture FIFO: default widths, pointer/level
// types and a constant-function clog2.
package sniff_pkg;

  localparam int SNIFF_DW = 8;
  localparam int SNIFF_AW = 8;

  typedef logic [SNIFF_AW-1:0] sniff_ptr_t;
  typedef logic [SNIFF_AW:0]   sniff_level_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/sniff_fifo_ram.sv
// Simple dual-port storage for sniff_fifo: one write port, one registered read
// port with enable. No reset so the array maps onto block RAM.
module sniff_fifo_ram #(
  parameter int DW = 8,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we_i) mem[waddr_i] <= wdata_i;
    if (re_i) rdata_o <= mem[raddr_i];
  end

endmodule

// File: rtl/sniff_fifo.sv
// Never-stalling capture FIFO with registered valid/ready output stage.
// Optional saturating drop counter enabled by `define SNIFF_FIFO_DROP_CNT_EN.
module sniff_fifo
  import sniff_pkg::*;
#(
  parameter int DW       = SNIFF_DW,
  parameter int AW       = SNIFF_AW,
  parameter int AF_LEVEL = 2**AW - 4,
  parameter int CW       = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [AW:0]   level,
  output logic          empty,
  output logic          full,
  output logic          almost_full,
  output logic          overflow,
  output logic [CW-1:0] drop_count
);

  localparam int          LW      = clog2(2**AW) + 1;
  localparam logic [LW-1:0] DEPTH_L = LW'(2**AW);
  localparam logic [LW-1:0] AF_L    = LW'(AF_LEVEL);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          empty_q, empty_d, full_q, full_d, af_q, af_d;
  logic          out_valid_q, out_valid_d, overflow_q, overflow_d;
  logic          wr_accept, wr_drop, fetch;

  // full is the registered flag, so a same-cycle fetch never rescues a write.
  always_comb begin
    wr_accept = in_valid && !full_q && !clear;
    wr_drop   = in_valid &&  full_q && !clear;
    fetch     = !empty_q && (!out_valid_q || out_ready) && !clear;

    wr_ptr_d    = wr_ptr_q + AW'(wr_accept);
    rd_ptr_d    = rd_ptr_q + AW'(fetch);
    level_d     = level_q + LW'(wr_accept) - LW'(fetch);
    overflow_d  = overflow_q || wr_drop;
    out_valid_d = out_valid_q;
    if (fetch)          out_valid_d = 1'b1;
    else if (out_ready) out_valid_d = 1'b0;

    if (clear) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      level_d     = '0;
      overflow_d  = 1'b0;
      out_valid_d = 1'b0;
    end

    empty_d = (level_d == '0);
    full_d  = (level_d == DEPTH_L);
    af_d    = (level_d >= AF_L);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      empty_q     <= 1'b1;
      full_q      <= 1'b0;
      af_q        <= 1'b0;
      out_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      empty_q     <= empty_d;
      full_q      <= full_d;
      af_q        <= af_d;
      out_valid_q <= out_valid_d;
      overflow_q  <= overflow_d;
    end
  end

  sniff_fifo_ram #(.DW(DW), .AW(AW)) u_ram (
    .clk     (clk),
    .we_i    (wr_accept),
    .waddr_i (wr_ptr_q),
    .wdata_i (in_data),
    .re_i    (fetch),
    .raddr_i (rd_ptr_q),
    .rdata_o (out_data)
  );

`ifdef SNIFF_FIFO_DROP_CNT_EN
  logic [CW-1:0] drop_q, drop_d;

  // Saturating; only reset clears it so losses survive a flush.
  always_comb begin
    drop_d = drop_q;
    if (wr_drop && (drop_q != {CW{1'b1}})) drop_d = drop_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) drop_q <= '0;
    else       drop_q <= drop_d;
  end

  assign drop_count = drop_q;
`else
  assign drop_count = '0;
`endif

  assign out_valid   = out_valid_q;
  assign level       = level_q;
  assign empty       = empty_q;
  assign full        = full_q;
  assign almost_full = af_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_sniff_fifo.sv
// Directed bench for sniff_fifo (DW=8, AW=4, AF_LEVEL=12, CW=4).
module tb_sniff_fifo;

  localparam int DW = 8;
  localparam int AW = 4;
  localparam int CW = 4;
`ifdef SNIFF_FIFO_DROP_CNT_EN
  localparam int EXP_DROP3 = 3;
  localparam int EXP_SAT   = 15;
`else
  localparam int EXP_DROP3 = 0;
  localparam int EXP_SAT   = 0;
`endif

  logic          clk = 1'b0;
  logic          reset, clear, in_valid, out_ready;
  logic [DW-1:0] in_data;
  logic          out_valid, empty, full, almost_full, overflow;
  logic [DW-1:0] out_data;
  logic [AW:0]   level;
  logic [CW-1:0] drop_count;

  int checks   = 0;
  int failures = 0;

  sniff_fifo #(.DW(DW), .AW(AW), .AF_LEVEL(12), .CW(CW)) dut (
    .clk         (clk),
    .reset       (reset),
    .clear       (clear),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .level       (level),
    .empty       (empty),
    .full        (full),
    .almost_full (almost_full),
    .overflow    (overflow),
    .drop_count  (drop_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge; outputs are sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [DW-1:0] sb[$];
  int            n_rx;

  initial begin
    reset = 1'b1; clear = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    tick(); tick();
    reset = 1'b0;
    chk("rst_level", level, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_af", almost_full, 0);
    chk("rst_ovalid", out_valid, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_drop", drop_count, 0);

    // Single word latency
    in_valid = 1'b1; in_data = 8'hA5;
    tick();
    in_valid = 1'b0;
    chk("t1_level_n1", level, 1);
    chk("t1_ovalid_n1", out_valid, 0);
    tick();
    chk("t1_level_n2", level, 0);
    chk("t1_empty_n2", empty, 1);
    chk("t1_ovalid_n2", out_valid, 1);
    chk("t1_data_n2", out_data, 8'hA5);
    tick();
    chk("t1_ovalid_n3", out_valid, 0);
    chk("t1_empty_n3", empty, 1);

    // Fill with consumer stalled: word 0 to output reg, 1..16 stored
    out_ready = 1'b0;
    for (int i = 0; i <= 16; i++) begin
      in_valid = 1'b1; in_data = DW'(i);
      tick();
      chk("t2_level", level, (i == 0) ? 1 : i);
      chk("t2_af", almost_full, (i >= 12) ? 1 : 0);
    end
    in_valid = 1'b0;
    chk("t2_full", full, 1);
    chk("t2_ovf", overflow, 0);
    chk("t2_ovalid", out_valid, 1);
    chk("t2_head", out_data, 8'h00);

    // Overflow from full
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = DW'(8'h80 + i);
      tick();
    end
    in_valid = 1'b0;
    chk("t3_ovf", overflow, 1);
    chk("t3_drop", drop_count, EXP_DROP3);
    chk("t3_level", level, 16);

    out_ready = 1'b1;
    for (int k = 0; k <= 16; k++) begin
      chk("t3_drain_vld", out_valid, 1);
      chk("t3_drain_data", out_data, DW'(k));
      tick();
    end
    chk("t3_drain_end_vld", out_valid, 0);
    chk("t3_drain_end_empty", empty, 1);
    chk("t3_ovf_sticky", overflow, 1);

    // 40 words in two bursts, consumer toggling ready, across pointer wraps
    n_rx = 0;
    for (int c = 0; c < 100; c++) begin
      in_valid  = ((c < 20) || (c >= 40 && c < 60));
      in_data   = DW'(8'h20 + ((c < 20) ? c : c - 20));
      out_ready = (c % 2 == 0);
      if (out_valid && out_ready) begin
        n_rx++;
        if (sb.size() != 0) chk("t4_order", out_data, sb.pop_front());
        else chk("t4_extra", sb.size(), 1);
      end
      if (in_valid) sb.push_back(in_data);
      tick();
    end
    in_valid = 1'b0;
    chk("t4_count", n_rx, 40);
    chk("t4_left", sb.size(), 0);
    chk("t4_ovf_still", overflow, 1);

    // Stall with data held
    out_ready = 1'b1; tick(); tick();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'h50; tick();
    in_data = 8'h51; tick();
    in_valid = 1'b0; tick();
    for (int s = 0; s < 5; s++) begin
      chk("t5_hold_vld", out_valid, 1);
      chk("t5_hold_data", out_data, 8'h50);
      tick();
    end
    out_ready = 1'b1;
    tick();
    chk("t5_next_vld", out_valid, 1);
    chk("t5_next_data", out_data, 8'h51);
    tick();
    chk("t5_done_vld", out_valid, 0);

    // Clear at level 7 with a concurrent write
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_data = DW'(8'h60 + i);
      tick();
    end
    chk("t6_level7", level, 7);
    clear = 1'b1; in_data = 8'hEE;
    tick();
    clear = 1'b0; in_valid = 1'b0;
    chk("t6_level", level, 0);
    chk("t6_empty", empty, 1);
    chk("t6_ovalid", out_valid, 0);
    chk("t6_ovf", overflow, 0);
    chk("t6_drop", drop_count, EXP_DROP3);
    tick();
    chk("t6_level_after", level, 0);
    chk("t6_ovalid_after", out_valid, 0);

    // Drop counter saturation (3 + 13 drops > 15), then reset clears it
    for (int i = 0; i < 30; i++) begin
      in_valid = 1'b1; in_data = DW'(i);
      tick();
    end
    in_valid = 1'b0;
    chk("t7_level", level, 16);
    chk("t7_ovf", overflow, 1);
    chk("t7_drop_sat", drop_count, EXP_SAT);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t7_rst_drop", drop_count, 0);
    chk("t7_rst_level", level, 0);
    chk("t7_rst_ovf", overflow, 0);
    chk("t7_rst_vld", out_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
